// File: rtl/cgra_cfg_pkg.sv
// cgra_cfg_pkg: shared configuration-bus field layout, constants and request type
package cgra_cfg_pkg;
    localparam int TILE_LSB   = 0;
    localparam int TILE_W     = 16;
    localparam int FEAT_LSB   = 16;
    localparam int FEAT_W     = 8;
    localparam int REG_LSB    = 24;
    localparam int REG_W      = 8;
    localparam int CFG_DATA_W = 32;
    localparam int CFG_ADDR_W = 32;

    localparam logic [TILE_W-1:0] BCAST_TILE_ID = 16'hFFFF;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
        logic                  write;
        logic                  read;
    } cfg_req_t;

    function automatic logic [TILE_W-1:0] addr_tile(input logic [CFG_ADDR_W-1:0] a);
        return a[TILE_LSB +: TILE_W];
    endfunction

    function automatic logic [FEAT_W-1:0] addr_feat(input logic [CFG_ADDR_W-1:0] a);
        return a[FEAT_LSB +: FEAT_W];
    endfunction

    function automatic logic [REG_W-1:0] addr_reg(input logic [CFG_ADDR_W-1:0] a);
        return a[REG_LSB +: REG_W];
    endfunction
endpackage

// File: rtl/tile_config_responder_if.sv
// tile_config_responder_if: configuration bus between a bitstream loader and a tile feature
interface tile_config_responder_if;
    import cgra_cfg_pkg::*;
    logic [CFG_ADDR_W-1:0] config_addr;
    logic [CFG_DATA_W-1:0] config_data;
    logic                  config_write;
    logic                  config_read;
    logic [CFG_DATA_W-1:0] read_data;
    logic                  read_data_valid;

    modport master (
        output config_addr, config_data, config_write, config_read,
        input  read_data, read_data_valid
    );

    modport slave (
        input  config_addr, config_data, config_write, config_read,
        output read_data, read_data_valid
    );
endinterface

// File: rtl/reset_sync.sv
// reset_sync: asynchronous-assert, synchronous-deassert active-low reset synchroniser
module reset_sync (
    input  logic clk_in,
    input  logic rst_in_n,
    output logic rst_out_n
);
    logic [1:0] sync;

    // shift ones in after release; any assertion clears both stages at once
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) sync <= 2'b00;
        else           sync <= {sync[0], 1'b1};
    end

    assign rst_out_n = sync[1];
endmodule

// File: rtl/tile_config_responder.sv
// tile_config_responder: tile-side config register bank with write decode and 2-cycle pipelined readback
module tile_config_responder
    import cgra_cfg_pkg::*;
#(
    parameter int                NUM_REGS   = 8,
    parameter logic [FEAT_W-1:0] FEATURE_ID = 8'h00,
    parameter logic [TILE_W-1:0] BCAST_ID   = BCAST_TILE_ID
) (
    input  logic                           clk_in,
    input  logic                           reset,
    input  logic [TILE_W-1:0]              tile_id,
    tile_config_responder_if.slave         bus,
    output logic [CFG_DATA_W*NUM_REGS-1:0] cfg_regs,
    output logic [NUM_REGS-1:0]            cfg_written,
    output logic                           cfg_err
);
    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    logic rst_n;

    reset_sync u_reset_sync (
        .clk_in    (clk_in),
        .rst_in_n  (reset),
        .rst_out_n (rst_n)
    );

    cfg_req_t req;
    assign req = '{addr: bus.config_addr, data: bus.config_data,
                   write: bus.config_write, read: bus.config_read};

    logic [REG_W-1:0] idx;
    logic feat_hit, wr_hit, rd_hit, in_range, wr_en, rd_go, err_set;

    assign idx      = addr_reg(req.addr);
    assign feat_hit = addr_feat(req.addr) == FEATURE_ID;
    assign wr_hit   = req.write & feat_hit &
                      (addr_tile(req.addr) == tile_id | addr_tile(req.addr) == BCAST_ID);
    assign rd_hit   = req.read & feat_hit & (addr_tile(req.addr) == tile_id);
    assign in_range = {1'b0, idx} < 9'(NUM_REGS);
    assign wr_en    = wr_hit & in_range;
    // a read colliding with any write in the same cycle is dropped
    assign rd_go    = rd_hit & ~req.write;
    assign err_set  = (wr_hit & ~in_range) | (rd_go & ~in_range) |
                      (req.write & req.read & (wr_hit | rd_hit));

    logic [NUM_REGS-1:0][CFG_DATA_W-1:0] regs, regs_nxt;
    logic [NUM_REGS-1:0]                 wr_sel;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_bank
        assign wr_sel[g]   = wr_en && idx == REG_W'(g);
        assign regs_nxt[g] = wr_sel[g] ? req.data : regs[g];
    end

    assign cfg_regs = regs;

    // register bank, write pulses and sticky error flag
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            regs        <= '0;
            cfg_written <= '0;
            cfg_err     <= 1'b0;
        end else begin
            regs        <= regs_nxt;
            cfg_written <= wr_sel;
            cfg_err     <= cfg_err | err_set;
        end
    end

    logic          s1_valid, s1_ok;
    logic [IW-1:0] s1_idx;

    // read pipeline; stage 2 reads the post-write bank so a same-cycle write is seen
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid            <= 1'b0;
            s1_ok               <= 1'b0;
            s1_idx              <= '0;
            bus.read_data       <= '0;
            bus.read_data_valid <= 1'b0;
        end else begin
            s1_valid            <= rd_go;
            s1_ok               <= in_range;
            s1_idx              <= idx[IW-1:0];
            bus.read_data       <= (s1_valid && s1_ok) ? regs_nxt[s1_idx] : '0;
            bus.read_data_valid <= s1_valid;
        end
    end
endmodule

// File: doc/tile_config_responder.md
Name: tile_config_responder

Overview:
- Tile-side end of the CGRA configuration bus: decodes the address/data pairs streamed from a bitstream loader and writes them into a bank of per-tile configuration registers.
- Provides pipelined readback of those registers so loaders and benches can verify the configuration.
- Instantiated once per feature inside each tile (PE or memory tile). Read data from every tile is OR-combined at the array level.

Parameters:
- NUM_REGS, 8, number of 32-bit config registers in this feature (1..256)
- FEATURE_ID, 8'h00, value of config_addr[23:16] that selects this feature
- BCAST_ID, 16'hFFFF, tile id that every tile accepts for writes (never for reads)

Ports:
- clk_in  in  1  clock, rising-edge
- reset  in  1  reset, asynchronous, active-low
- tile_id  in  16  static id of the enclosing tile
- config_addr  in  32  [15:0] tile id, [23:16] feature, [31:24] register index
- config_data  in  32  write data
- config_write  in  1  write strobe, one transfer per cycle
- config_read  in  1  read strobe, one transfer per cycle
- read_data  out  32  readback data; 0 when read_data_valid=0
- read_data_valid  out  1  read_data carries a response this cycle
- cfg_regs  out  32*NUM_REGS  flattened register bank; reg i at [32*i+31:32*i]
- cfg_written  out  NUM_REGS  one-cycle pulse per register written
- cfg_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset=0, asynchronous): cfg_regs=0, cfg_written=0, read_data=0, read_data_valid=0, cfg_err=0, read pipeline emptied. Deassertion is synchronised internally with a 2-flop synchroniser, so reset release takes effect after 2 clk_in edges.
- Hit decode:
  - wr_hit = config_write & (addr[15:0]==tile_id | addr[15:0]==BCAST_ID) & addr[23:16]==FEATURE_ID.
  - rd_hit = config_read & addr[15:0]==tile_id & addr[23:16]==FEATURE_ID.
- Write: on a wr_hit edge with idx=addr[31:24] < NUM_REGS, cfg_regs[idx] <= config_data. cfg_written[idx] pulses high the following cycle for exactly one cycle. The new value is visible on cfg_regs one cycle after the strobe.
- Out-of-range write (idx >= NUM_REGS): no register changes, no pulse, cfg_err <= 1.
- Read: fixed 2-cycle latency, fully pipelined.
  - Stage 1 registers the hit flag and idx.
  - Stage 2 registers cfg_regs[idx] into read_data and sets read_data_valid=1.
  - Reads issued on back-to-back cycles produce back-to-back valid cycles.
  - Out-of-range read returns 32'h0 with valid=1 and sets cfg_err.
  - A miss (wrong tile or feature) produces no response; read_data stays 0.
- Stage 2 samples the register bank as it stands after any write committed in the same cycle as the stage-1 to stage-2 transfer (write-before-read ordering). A read issued one cycle after a write to the same register returns the new value.
- Simultaneous config_write & config_read in one cycle: the write is performed; the read is dropped with no response; cfg_err <= 1 if either strobe hits this tile.
- cfg_err is cleared only by reset.
- Assertion of reset mid-read: in-flight responses are discarded; no valid is emitted after release.
- A broadcast write that also matches tile_id is performed once.

Decomposition:
- Shared package cgra_cfg_pkg holds:
  - address field constants: TILE_LSB=0, TILE_W=16, FEAT_LSB=16, FEAT_W=8, REG_LSB=24, REG_W=8
  - CFG_DATA_W=32
  - BCAST_TILE_ID
  - the struct type cfg_req_t {addr, data, write, read}
- Sub-module: reset_sync (2-flop async-assert/sync-deassert), reusable by the other tile blocks.

Test Plan:
- Write/readback: with tile_id=16'h18, FEATURE_ID=0, write addr 32'h02000018 data 32'hDEADBEEF. Then cfg_regs[2]=DEADBEEF next cycle and cfg_written=8'b0000_0100 for one cycle. A read of 32'h02000018 gives read_data=DEADBEEF with valid exactly 2 cycles after the strobe.
- Filtering: write 32'h01000019 data 1 (wrong tile) leaves all regs 0. Write 32'h0100FFFF data 32'h55 sets reg1=32'h55. Read 32'h0100FFFF gives no valid.
- Pipelined reads: preload regs 0..3 with 10,11,12,13, then issue reads on 4 consecutive cycles. Required response: 4 consecutive valid cycles returning 10,11,12,13, with read_data=0 on every other cycle.
- Errors: write 32'h09000018 (idx 9 >= 8) sets cfg_err=1 with no register change. A simultaneous write+read to the tile performs the write, returns no read response, and cfg_err stays 1.
- Write-then-read hazard: write reg3=32'hA5A5A5A5, then on the next cycle read reg3. Required response: A5A5A5A5.
- Reset mid-operation: issue a read, assert reset on the next cycle. Required response: no valid ever appears, all outputs 0 while reset is low, and regs are still 0 after release and a 2-cycle sync.
